// File: rtl/sdram_pattern_tester_pkg.sv
// Shared types and constants for the SDRAM pattern tester: state encoding,
// LED bit positions and the LFSR polynomial.
package sdram_test_pkg;

   typedef enum logic [2:0] {
      INIT      = 3'd0,
      WR_REQ    = 3'd1,
      RD_SETUP  = 3'd2,
      RD_REQ    = 3'd3,
      RD_WAIT   = 3'd4,
      PASS_DONE = 3'd5,
      FAIL      = 3'd6
   } state_t;

   localparam int LED_PASS    = 7;
   localparam int LED_FAIL    = 6;
   localparam int LED_TIMEOUT = 5;
   localparam int LED_CNT_W   = 5;

   localparam logic [31:0] LFSR_MASK = 32'h80200003;

   // Galois form, x^32+x^22+x^2+x+1, shifting right
   function automatic logic [31:0] lfsr_next(input logic [31:0] v);
      return (v >> 1) ^ (v[0] ? LFSR_MASK : 32'h0);
   endfunction

endpackage

// File: rtl/sdram_pattern_tester_if.sv
// Request/response bus between the pattern tester (master) and the SDRAM
// controller (slave).
interface sdram_pattern_tester_if #(
   parameter int ADDR_W = 23,
   parameter int DATA_W = 32
) ();

   logic [ADDR_W-1:0] addr;
   logic              rw;
   logic [DATA_W-1:0] data_in;
   logic [DATA_W-1:0] data_out;
   logic              busy;
   logic              in_valid;
   logic              out_valid;

   modport master (
      output addr, rw, data_in, in_valid,
      input  data_out, busy, out_valid
   );

   modport slave (
      input  addr, rw, data_in, in_valid,
      output data_out, busy, out_valid
   );

endinterface

// File: rtl/sdram_pattern_tester_lfsr32.sv
// 32-bit Galois LFSR shared by the write and read-back passes; load has
// priority over step so a reseed never also advances.
module lfsr32
   import sdram_test_pkg::*;
(
   input  logic        clk,
   input  logic        load,
   input  logic [31:0] load_val,
   input  logic        step,
   output logic [31:0] q
);

   logic [31:0] q_q;
   logic [31:0] q_d;

   always_comb begin
      q_d = q_q;
      if (load) begin
         q_d = load_val;
      end else if (step) begin
         q_d = lfsr_next(q_q);
      end
   end

   always_ff @(posedge clk) begin
      q_q <= q_d;
   end

   assign q = q_q;

endmodule

// File: rtl/sdram_pattern_tester.sv
// Self-running SDRAM traffic generator/checker: writes an LFSR sequence over
// the address window, reads it back, compares, and reports on 8 LEDs.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// INIT      | controller still initialising, wait for busy low
// WR_REQ    | issuing write of lfsr word at addr
// RD_SETUP  | rewind lfsr to pass seed and addr to START_ADDR
// RD_REQ    | issuing read at addr
// RD_WAIT   | read outstanding, waiting for out_valid
// PASS_DONE | window verified, bump pass count and seed
// FAIL      | sticky error (data mismatch or watchdog), bus idle
module sdram_pattern_tester
   import sdram_test_pkg::*;
#(
   parameter int                 ADDR_W     = 23,
   parameter int                 DATA_W     = 32,
   parameter logic [ADDR_W-1:0]  START_ADDR = 23'h000000,
   parameter logic [ADDR_W-1:0]  END_ADDR   = 23'h0003FF,
   parameter logic [31:0]        SEED       = 32'hACE12345,
   parameter int                 TIMEOUT    = 4096
) (
   input  logic                   clk,
   input  logic                   rst,
   sdram_pattern_tester_if.master bus,
   output logic [7:0]             leds,
   output logic [ADDR_W-1:0]      fail_addr
);

   localparam int WDOG_W = $clog2(TIMEOUT + 1);

   state_t                 state_q, state_d;
   logic [ADDR_W-1:0]      addr_q, addr_d;
   logic [ADDR_W-1:0]      fail_addr_q, fail_addr_d;
   logic                   in_valid_q, in_valid_d;
   logic [WDOG_W-1:0]      wdog_q, wdog_d;
   logic [31:0]            seed_q, seed_d;
   logic [LED_CNT_W-1:0]   pass_count_q, pass_count_d;
   logic                   pass_q, pass_d;
   logic                   fail_q, fail_d;
   logic                   timeout_q, timeout_d;

   logic                   lfsr_load;
   logic [31:0]            lfsr_load_val;
   logic                   lfsr_step;
   logic [31:0]            lfsr_q;

   logic                   accept;
   logic                   wdog_run;
   logic                   wdog_expired;
   logic [31:0]            seed_inc;

   lfsr32 u_lfsr (
      .clk      (clk),
      .load     (lfsr_load),
      .load_val (lfsr_load_val),
      .step     (lfsr_step),
      .q        (lfsr_q)
   );

   assign accept       = in_valid_q && !bus.busy;
   assign wdog_run     = (((state_q == WR_REQ) || (state_q == RD_REQ)) && bus.busy)
                         || (state_q == RD_WAIT);
   assign wdog_expired = wdog_run && (wdog_q == WDOG_W'(TIMEOUT - 1));
   // an all-zero seed would lock the LFSR, so the wrap goes to 1
   assign seed_inc     = (seed_q == 32'hFFFF_FFFF) ? 32'd1 : seed_q + 32'd1;

   always_comb begin
      state_d       = state_q;
      addr_d        = addr_q;
      fail_addr_d   = fail_addr_q;
      seed_d        = seed_q;
      pass_count_d  = pass_count_q;
      pass_d        = pass_q;
      fail_d        = fail_q;
      timeout_d     = timeout_q;
      lfsr_load     = 1'b0;
      lfsr_load_val = seed_q;
      lfsr_step     = 1'b0;
      wdog_d        = wdog_run ? wdog_q + 1'b1 : '0;

      case (state_q)
         INIT: begin
            if (!bus.busy) begin
               state_d = WR_REQ;
               addr_d  = START_ADDR;
            end
         end
         WR_REQ: begin
            if (accept) begin
               lfsr_step = 1'b1;
               if (addr_q == END_ADDR) begin
                  state_d = RD_SETUP;
               end else begin
                  addr_d = addr_q + 1'b1;
               end
            end else if (wdog_expired) begin
               state_d   = FAIL;
               timeout_d = 1'b1;
            end
         end
         RD_SETUP: begin
            lfsr_load     = 1'b1;
            lfsr_load_val = seed_q;
            addr_d        = START_ADDR;
            state_d       = RD_REQ;
         end
         RD_REQ: begin
            if (accept) begin
               state_d = RD_WAIT;
            end else if (wdog_expired) begin
               state_d   = FAIL;
               timeout_d = 1'b1;
            end
         end
         RD_WAIT: begin
            // a compare in the expiry cycle takes precedence over the timeout
            if (bus.out_valid) begin
               wdog_d = '0;
               if (bus.data_out != DATA_W'(lfsr_q)) begin
                  state_d = FAIL;
               end else begin
                  lfsr_step = 1'b1;
                  if (addr_q == END_ADDR) begin
                     state_d = PASS_DONE;
                  end else begin
                     addr_d  = addr_q + 1'b1;
                     state_d = RD_REQ;
                  end
               end
            end else if (wdog_expired) begin
               state_d   = FAIL;
               timeout_d = 1'b1;
            end
         end
         PASS_DONE: begin
            pass_d        = 1'b1;
            pass_count_d  = pass_count_q + 1'b1;
            seed_d        = seed_inc;
            lfsr_load     = 1'b1;
            lfsr_load_val = seed_inc;
            addr_d        = START_ADDR;
            state_d       = WR_REQ;
         end
         FAIL: begin
         end
         default: begin
            state_d = INIT;
         end
      endcase

      if ((state_d == FAIL) && (state_q != FAIL)) begin
         fail_d      = 1'b1;
         fail_addr_d = addr_q;
      end

      // request drops for one cycle after acceptance
      in_valid_d = ((state_d == WR_REQ) || (state_d == RD_REQ)) && !accept;

      if (!rst) begin
         lfsr_load     = 1'b1;
         lfsr_load_val = SEED;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q      <= INIT;
         addr_q       <= '0;
         fail_addr_q  <= '0;
         in_valid_q   <= 1'b0;
         wdog_q       <= '0;
         seed_q       <= SEED;
         pass_count_q <= '0;
         pass_q       <= 1'b0;
         fail_q       <= 1'b0;
         timeout_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         fail_addr_q  <= fail_addr_d;
         in_valid_q   <= in_valid_d;
         wdog_q       <= wdog_d;
         seed_q       <= seed_d;
         pass_count_q <= pass_count_d;
         pass_q       <= pass_d;
         fail_q       <= fail_d;
         timeout_q    <= timeout_d;
      end
   end

   assign bus.addr     = addr_q;
   assign bus.in_valid = in_valid_q;
   assign bus.rw       = (state_q == WR_REQ);
   assign bus.data_in  = (state_q == WR_REQ) ? DATA_W'(lfsr_q) : '0;

   assign leds      = {pass_q, fail_q, timeout_q, pass_count_q};
   assign fail_addr = fail_addr_q;

endmodule

// File: tb/tb_sdram_pattern_tester.sv
// Directed bench for sdram_pattern_tester with a behavioural SDRAM controller
// model (random busy gaps, 3-8 cycle read latency, fault injection knobs).
module tb_sdram_pattern_tester;

   localparam int TIMEOUT = 64;

   logic        clk;
   logic        rst;
   logic [7:0]  leds;
   logic [22:0] fail_addr;

   int checks = 0;
   int errors = 0;

   sdram_pattern_tester_if #(.ADDR_W(23), .DATA_W(32)) bus ();

   sdram_pattern_tester #(
      .ADDR_W     (23),
      .DATA_W     (32),
      .START_ADDR (23'h000000),
      .END_ADDR   (23'h000003),
      .SEED       (32'h00000001),
      .TIMEOUT    (TIMEOUT)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus.master),
      .leds      (leds),
      .fail_addr (fail_addr)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // controller model knobs
   bit busy_hold, busy_rand, busy_after_wr, corrupt_en, drop_one, spurious;
   // controller model state / logs
   bit          wr_seen, dropped, rd_pend;
   int          rd_lat;
   logic [22:0] rd_addr, last_rd_addr;
   logic [31:0] mem [4];
   logic [31:0] wr_data_q [$];
   logic [22:0] wr_addr_q [$];
   int          wr_cnt = 0;
   int          rd_cnt = 0;
   int          spur_cnt = 0;

   // decisions are made at the falling edge for the following rising edge
   initial begin
      bus.busy      = 1'b1;
      bus.out_valid = 1'b0;
      bus.data_out  = '0;
      rd_pend = 0; wr_seen = 0; dropped = 0; rd_lat = 0;
      rd_addr = '0; last_rd_addr = '0;
      forever begin
         @(negedge clk);
         bus.out_valid = 1'b0;
         bus.data_out  = '0;
         bus.busy = busy_hold || (busy_after_wr && wr_seen)
                    || (busy_rand && ($urandom_range(0, 3) == 0));
         if (!rst) begin
            rd_pend = 0; wr_seen = 0; dropped = 0;
         end else begin
            if (rd_pend) begin
               rd_lat--;
               if (rd_lat == 0) begin
                  rd_pend = 0;
                  if (drop_one && !dropped) begin
                     dropped = 1;
                  end else begin
                     bus.out_valid = 1'b1;
                     bus.data_out  = mem[rd_addr[1:0]]
                                     ^ ((corrupt_en && rd_addr == 23'd2) ? 32'd1 : 32'd0);
                  end
               end
            end else if (spurious && bus.in_valid && bus.rw) begin
               bus.out_valid = 1'b1;
               bus.data_out  = 32'hDEADBEEF;
               spur_cnt++;
            end
            if (bus.in_valid && !bus.busy) begin
               if (bus.rw) begin
                  mem[bus.addr[1:0]] = bus.data_in;
                  wr_data_q.push_back(bus.data_in);
                  wr_addr_q.push_back(bus.addr);
                  wr_cnt++;
                  wr_seen = 1;
               end else begin
                  rd_pend      = 1;
                  rd_addr      = bus.addr;
                  last_rd_addr = bus.addr;
                  rd_lat       = $urandom_range(3, 8);
                  rd_cnt++;
               end
            end
         end
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   int iv, wb, rb, passes;
   logic [4:0] prev_cnt;
   logic [31:0] pass0 [4];

   initial begin
      pass0[0] = 32'h00000001; pass0[1] = 32'h80200003;
      pass0[2] = 32'hC0300002; pass0[3] = 32'h60180001;
      busy_hold = 1; busy_rand = 0; busy_after_wr = 0;
      corrupt_en = 0; drop_one = 0; spurious = 0;

      // reset values
      rst = 1'b0;
      repeat (3) tick();
      check("rst_addr",      64'(bus.addr),     64'd0);
      check("rst_rw",        64'(bus.rw),       64'd0);
      check("rst_data_in",   64'(bus.data_in),  64'd0);
      check("rst_in_valid",  64'(bus.in_valid), 64'd0);
      check("rst_leds",      64'(leds),         64'd0);
      check("rst_fail_addr", 64'(fail_addr),    64'd0);

      // 1: busy through controller init, then one clean pass
      rst = 1'b1;
      iv = 0;
      repeat (200) begin tick(); if (bus.in_valid) iv++; end
      check("t1_no_req_while_busy", 64'(iv), 64'd0);
      busy_hold = 0; busy_rand = 1;
      for (int i = 0; i < 2000 && !leds[7]; i++) tick();
      check("t1_leds",  64'(leds),   64'h81);
      check("t1_reads", 64'(rd_cnt), 64'd4);
      for (int k = 0; k < 4; k++) begin
         check($sformatf("t1_wr_data%0d", k), 64'(wr_data_q[k]), 64'(pass0[k]));
         check($sformatf("t1_wr_addr%0d", k), 64'(wr_addr_q[k]), 64'(k));
      end

      // 2: corrupted read at addr 2
      rst = 1'b0; corrupt_en = 1; tick(); rst = 1'b1;
      for (int i = 0; i < 2000 && !leds[6]; i++) tick();
      check("t2_leds",      64'(leds),      64'h40);
      check("t2_fail_addr", 64'(fail_addr), 64'd2);
      iv = 0;
      repeat (1000) begin tick(); if (bus.in_valid) iv++; end
      check("t2_idle", 64'(iv), 64'd0);

      // 3: busy stuck after first write acceptance
      rst = 1'b0; corrupt_en = 0; busy_after_wr = 1; tick(); rst = 1'b1;
      wb = wr_cnt;
      for (int i = 0; i < 500 && wr_cnt == wb; i++) tick();
      check("t3_first_write", 64'(wr_cnt), 64'(wb + 1));
      repeat (TIMEOUT - 1) tick();
      check("t3_leds_before", 64'(leds), 64'h00);
      tick();
      check("t3_leds_timeout", 64'(leds), 64'h60);

      // 4a: lost read response
      rst = 1'b0; busy_after_wr = 0; drop_one = 1; tick(); rst = 1'b1;
      for (int i = 0; i < 1000 && !leds[5]; i++) tick();
      check("t4_leds",      64'(leds),      64'h60);
      check("t4_fail_addr", 64'(fail_addr), 64'd0);

      // 4b: stray out_valid while writing
      rst = 1'b0; drop_one = 0; spurious = 1; tick(); rst = 1'b1;
      for (int i = 0; i < 2000 && !leds[7]; i++) tick();
      check("t4_spurious_leds", 64'(leds), 64'h81);
      check("t4_spurious_seen", 64'(spur_cnt > 0), 64'd1);

      // 5: reset in the middle of the read at addr 1
      rst = 1'b0; spurious = 0; tick(); rst = 1'b1;
      rb = rd_cnt;
      for (int i = 0; i < 1000 && rd_cnt < rb + 2; i++) tick();
      check("t5_rd_addr", 64'(last_rd_addr), 64'd1);
      rst = 1'b0;
      tick();
      check("t5_addr",     64'(bus.addr),     64'd0);
      check("t5_rw",       64'(bus.rw),       64'd0);
      check("t5_data_in",  64'(bus.data_in),  64'd0);
      check("t5_in_valid", 64'(bus.in_valid), 64'd0);
      check("t5_leds",     64'(leds),         64'd0);
      wb = wr_cnt;
      rst = 1'b1;
      for (int i = 0; i < 1000 && wr_cnt < wb + 4; i++) tick();
      for (int k = 0; k < 4; k++)
         check($sformatf("t5_wr_data%0d", k), 64'(wr_data_q[wb + k]), 64'(pass0[k]));

      // 6: 33 passes, pass counter wrap and seed increment
      rst = 1'b0; tick(); rst = 1'b1;
      wb = wr_cnt; passes = 0; prev_cnt = 5'd0;
      for (int i = 0; i < 20000 && passes < 33; i++) begin
         tick();
         if (leds[4:0] != prev_cnt) begin passes++; prev_cnt = leds[4:0]; end
      end
      check("t6_passes",   64'(passes),    64'd33);
      check("t6_count",    64'(leds[4:0]), 64'd1);
      check("t6_pass_led", 64'(leds[7]),   64'd1);
      check("t6_pass1_last", 64'(wr_data_q[wb + 7]), 64'hC0300002);
      for (int k = 0; k < 33; k++)
         check($sformatf("t6_seed%0d", k), 64'(wr_data_q[wb + 4 * k]), 64'(k + 1));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
